// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [31:0] NOP_INST  = 32'h00000013;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_width_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_data_ram.sv
// Word-organised data RAM: asynchronous read, synchronous byte-enabled write.
module lsu_data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: captures Execute outputs, services loads/stores with a fixed stall.
// Optional LSU_MISALIGN_CHECK_EN turns misaligned accesses into flagged no-ops.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exe_inst,
    input  logic [31:0] exe_result,
    input  logic [31:0] exe_store_data,
    output logic [31:0] mem_inst,
    output logic [31:0] mem_addr,
    output logic        freeze_cpu,
    output logic [31:0] write_back_inst,
    output logic [31:0] mem_result,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (ACCESS_LATENCY < 1) ? 1 : $clog2(ACCESS_LATENCY + 1);
    localparam logic [CW-1:0] LAT_C = CW'(ACCESS_LATENCY);

    lsu_state_t  state_q;
    logic [CW-1:0] wait_cnt_q;
    logic [31:0] mem_inst_q, mem_addr_q, wdata_q, wb_inst_q, mem_result_q;

    logic [2:0]  f3;
    logic        is_load, is_store, is_half, is_word, mis, exe_is_mem;
    logic [AW+1:0] ea;
    logic [15:0] sh;
    logic [31:0] rdata, ld_data, st_data, result_d;
    logic [3:0]  be, ram_be;

    assign f3         = mem_inst_q[14:12];
    assign is_load    = mem_inst_q[6:0] == OPC_LOAD;
    assign is_store   = mem_inst_q[6:0] == OPC_STORE;
    assign is_half    = (f3 == F3_H) || (is_load && f3 == F3_HU);
    assign is_word    = f3 == F3_W;
    assign exe_is_mem = (exe_inst[6:0] == OPC_LOAD) || (exe_inst[6:0] == OPC_STORE);

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = (is_load || is_store) &&
                 ((is_half && mem_addr_q[0]) || (is_word && mem_addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Low address bits are forced to the access size; with the check enabled
    // misaligned accesses are suppressed separately, so forcing is harmless.
    always_comb begin
        ea = mem_addr_q[AW+1:0];
        if (is_word)      ea[1:0] = 2'b00;
        else if (is_half) ea[0]   = 1'b0;
        sh = 16'(rdata >> {ea[1:0], 3'b000});

        ld_data = '0;
        case (f3)
            F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ld_data = {{16{sh[15]}}, sh};
            F3_W:    ld_data = rdata;
            F3_BU:   ld_data = {24'b0, sh[7:0]};
            F3_HU:   ld_data = {16'b0, sh};
            default: ld_data = '0;
        endcase

        be      = 4'b0000;
        st_data = wdata_q;
        case (f3)
            F3_B: begin be = 4'b0001 << ea[1:0]; st_data = {4{wdata_q[7:0]}};  end
            F3_H: begin be = ea[1] ? 4'b1100 : 4'b0011; st_data = {2{wdata_q[15:0]}}; end
            F3_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase

        ram_be   = (state_q == DONE && is_store && !mis) ? be : 4'b0000;
        result_d = is_load ? (mis ? 32'b0 : ld_data) : mem_addr_q;
    end

    lsu_data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .addr_i  (ea[AW+1:2]),
        .be_i    (ram_be),
        .wdata_i (st_data),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            mem_inst_q   <= NOP_INST;
            mem_addr_q   <= '0;
            wdata_q      <= '0;
            wb_inst_q    <= NOP_INST;
            mem_result_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            wb_inst_q  <= NOP_INST;
            if (wait_cnt_q + 1'b1 == LAT_C) state_q <= DONE;
        end else begin
            wb_inst_q    <= mem_inst_q;
            mem_result_q <= result_d;
            mem_inst_q   <= exe_inst;
            mem_addr_q   <= exe_result;
            wdata_q      <= exe_store_data;
            wait_cnt_q   <= '0;
            if (!exe_is_mem)       state_q <= IDLE;
            else if (LAT_C == '0)  state_q <= DONE;
            else                   state_q <= WAIT;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         misalign_q <= 1'b0;
        else if (state_q == DONE && mis) misalign_q <= 1'b1;
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign freeze_cpu      = state_q == WAIT;
    assign mem_inst        = mem_inst_q;
    assign mem_addr        = mem_addr_q;
    assign write_back_inst = wb_inst_q;
    assign mem_result      = mem_result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Random + directed bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

    localparam int DW  = 64;
    localparam int LAT = 2;
    localparam int SZ  = DW * 4;
    localparam int BW  = $clog2(SZ);
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 0;
    logic        rst;
    logic [31:0] exe_inst, exe_result, exe_store_data;
    logic [31:0] mem_inst, mem_addr, write_back_inst, mem_result;
    logic        freeze_cpu, misalign_err;

    load_store_unit #(.DEPTH_WORDS(DW), .ACCESS_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .exe_inst(exe_inst), .exe_result(exe_result),
        .exe_store_data(exe_store_data), .mem_inst(mem_inst), .mem_addr(mem_addr),
        .freeze_cpu(freeze_cpu), .write_back_inst(write_back_inst),
        .mem_result(mem_result), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [SZ];
    logic [31:0] m_inst, m_addr, m_wd, e_wb, e_res;
    int          m_left;
    logic        e_err;

    function automatic bit is_ld(input logic [31:0] i); return i[6:0] == 7'h03; endfunction
    function automatic bit is_st(input logic [31:0] i); return i[6:0] == 7'h23; endfunction

    function automatic bit half_op(input logic [31:0] i);
        return (i[14:12] == 3'd1) || (is_ld(i) && i[14:12] == 3'd5);
    endfunction

    function automatic logic [31:0] eaddr(input logic [31:0] i, input logic [31:0] a);
        if (i[14:12] == 3'd2) return {a[31:2], 2'b00};
        if (half_op(i))       return {a[31:1], 1'b0};
        return a;
    endfunction

    function automatic bit misal(input logic [31:0] i, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!(is_ld(i) || is_st(i))) return 0;
        return (half_op(i) && a[0]) || (i[14:12] == 3'd2 && a[1:0] != 2'b00);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] i, input logic [31:0] a);
        logic [31:0] e;
        logic [7:0]  b0, b1, b2, b3;
        e  = eaddr(i, a);
        b0 = mb[BW'(e)];      b1 = mb[BW'(e + 1)];
        b2 = mb[BW'(e + 2)];  b3 = mb[BW'(e + 3)];
        if (misal(i, a)) return 0;
        case (i[14:12])
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            3'd4:    return {24'b0, b0};
            3'd5:    return {16'b0, b1, b0};
            default: return 0;
        endcase
    endfunction

    function automatic int st_bytes(input logic [31:0] i);
        case (i[14:12])
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inst <= NOP; m_addr <= 0; m_wd <= 0; m_left <= 0;
            e_wb <= NOP; e_res <= 0; e_err <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            e_wb   <= NOP;
        end else begin
            e_wb  <= m_inst;
            e_res <= is_ld(m_inst) ? ld_val(m_inst, m_addr) : m_addr;
            if (is_st(m_inst) && !misal(m_inst, m_addr))
                for (int i = 0; i < 4; i++)
                    if (i < st_bytes(m_inst))
                        mb[BW'(eaddr(m_inst, m_addr) + 32'(i))] <= m_wd[8*i +: 8];
            if (misal(m_inst, m_addr)) e_err <= 1'b1;
            m_inst <= exe_inst;
            m_addr <= exe_result;
            m_wd   <= exe_store_data;
            m_left <= (is_ld(exe_inst) || is_st(exe_inst)) ? LAT : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("freeze",    32'(freeze_cpu), 32'(m_left != 0));
            check("wb_inst",   write_back_inst, e_wb);
            check("mem_result", mem_result,    e_res);
            check("mem_inst",  mem_inst,       m_inst);
            check("mem_addr",  mem_addr,       m_addr);
            check("misalign",  32'(misalign_err), 32'(e_err));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h0, f3, 5'd2, opc};
    endfunction

    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (freeze_cpu && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            vecs++; errs++;
            $display("FAIL issue_timeout: freeze stuck for %0d cycles", n);
        end
        exe_inst = i; exe_result = a; exe_store_data = d;
        @(posedge clk); #1;
    endtask

    task automatic wait_wb(input string nm, input logic [31:0] i);
        int n = 0;
        while (write_back_inst !== i && n < 50) begin @(posedge clk); #1; n++; end
        check(nm, write_back_inst, i);
    endtask

    task automatic run(input string nm, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        issue(i, a, d);
        issue(NOP, 0, 0);
        wait_wb({nm, "_wb"}, i);
        check(nm, mem_result, exp);
    endtask

    logic [31:0] iw [DW];
    logic [31:0] r;
    int          nf;

    initial begin
        rst = 1; exe_inst = NOP; exe_result = 0; exe_store_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb",     write_back_inst, NOP);
        check("rst_minst",  mem_inst,        NOP);
        check("rst_maddr",  mem_addr,        0);
        check("rst_result", mem_result,      0);
        check("rst_freeze", 32'(freeze_cpu), 0);
        check("rst_err",    32'(misalign_err), 0);
        rst = 0;
        chk_en = 1;

        for (int w = 0; w < DW; w++) begin
            iw[w] = $urandom();
            issue(mk(7'h23, 3'd2), 32'(w * 4), iw[w]);
        end
        issue(NOP, 0, 0);

        issue(32'h00500093, 5, 0);
        check("addi_nofreeze", 32'(freeze_cpu), 0);
        issue(NOP, 0, 0);
        wait_wb("addi_wb", 32'h00500093);
        check("addi_result", mem_result, 5);

        issue(mk(7'h23, 3'd2), 32'h10, 32'hDEADBEEF);
        nf = 0;
        while (freeze_cpu && nf < 10) begin @(posedge clk); #1; nf++; end
        check("sw_stall_cycles", 32'(nf), 2);
        issue(NOP, 0, 0);
        wait_wb("sw_wb", mk(7'h23, 3'd2));
        run("lw_deadbeef", mk(7'h03, 3'd2), 32'h10, 0, 32'hDEADBEEF);
        run("lb_13",  mk(7'h03, 3'd0), 32'h13, 0, 32'hFFFFFFDE);
        run("lbu_13", mk(7'h03, 3'd4), 32'h13, 0, 32'h000000DE);
        run("sh_12",  mk(7'h23, 3'd1), 32'h12, 32'h00001234, 32'h12);
        run("lw_10",  mk(7'h03, 3'd2), 32'h10, 0, 32'h1234BEEF);
`ifdef LSU_MISALIGN_CHECK_EN
        run("lw_11_mis", mk(7'h03, 3'd2), 32'h11, 0, 32'h0);
        check("mis_err_set", 32'(misalign_err), 1);
        run("addi_after_mis", 32'h00500093, 7, 0, 7);
        check("mis_err_sticky", 32'(misalign_err), 1);
`else
        run("lw_11", mk(7'h03, 3'd2), 32'h11, 0, 32'h1234BEEF);
        check("mis_err_tied", 32'(misalign_err), 0);
`endif

        // reset on the second stall cycle aborts the store
        issue(mk(7'h23, 3'd2), 32'h20, 32'h55555555);
        @(posedge clk); #1;
        check("abort_freeze", 32'(freeze_cpu), 1);
        rst = 1; exe_inst = NOP; exe_result = 0; exe_store_data = 0;
        #1;
        check("abort_wb",     write_back_inst, NOP);
        check("abort_minst",  mem_inst,        NOP);
        check("abort_result", mem_result,      0);
        check("abort_freeze0", 32'(freeze_cpu), 0);
        @(posedge clk); #1;
        rst = 0;
        run("word8_intact", mk(7'h03, 3'd2), 32'h20, 0, iw[8]);

        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            case ($urandom_range(0, 2))
                0:       begin r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h13 : 7'h33; end
                1:       r[6:0] = 7'h03;
                default: r[6:0] = 7'h23;
            endcase
            issue(r, $urandom(), $urandom());
        end
        issue(NOP, 0, 0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage block between Execute and Write_Back_Control: the responder for the pipeline's load/store requests. It latches the instruction and ALU result from Execute and services LOAD/STORE against an internal byte-addressable data RAM with fixed multi-cycle latency. While an access is in progress it asserts `freeze_cpu`, which stalls InstructionDecode and Execute. It then hands `write_back_inst`/`mem_result` to write-back as an aligned pair.

## Interface
- Reset is asynchronous and active-high. The block uses one clock: `clk`, with reset `rst`.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of 2.
- `ACCESS_LATENCY`, default 2: number of stall cycles per load/store; 0 is legal and means no stall.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  async active-high reset.
- `exe_inst`  in  32  instruction leaving Execute.
- `exe_result`  in  32  ALU result; this is the effective address for a load/store.
- `exe_store_data`  in  32  forwarded rs2 value, used by stores.
- `mem_inst`  out  32  instruction held in the M stage; also feeds decode forwarding.
- `mem_addr`  out  32  captured `exe_result`.
- `freeze_cpu`  out  1  pipeline stall, combinational from state.
- `write_back_inst`  out  32  instruction presented to write-back.
- `mem_result`  out  32  write-back data, aligned with `write_back_inst`.
- `misalign_err`  out  1  sticky misaligned-access flag (see Configuration).

## Operation
- The M-stage registers `mem_inst`, `mem_addr` and `wdata` capture the Execute outputs on every edge where `freeze_cpu`=0.
- A memory op is one where `mem_inst[6:0]` is LOAD (0000011) or STORE (0100011).
- The FSM has three states:
  - IDLE: M holds a non-memory op.
  - WAIT: a memory op with `wait_cnt` < `ACCESS_LATENCY`; `freeze_cpu`=1.
  - DONE: a memory op with `wait_cnt` == `ACCESS_LATENCY`; `freeze_cpu`=0.
- `wait_cnt` clears whenever M captures, and increments each WAIT cycle.
- At the DONE edge (or the IDLE edge), the outputs advance:
  - `write_back_inst` <= `mem_inst`.
  - `mem_result` <= loaded data for a load; otherwise `mem_addr`.
- A store commits its byte lanes to the RAM only at the DONE edge.
- At a WAIT edge, `write_back_inst` <= NOP (32'h00000013), so the register file is never written twice.
- Load funct3 decoding:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the halfword.
  - Any other funct3 returns 0.
- Store funct3 decoding: 000 SB, 001 SH, 010 SW. Any other funct3 writes nothing.
- Byte lane = `mem_addr[1:0]`. Word index = `mem_addr[$clog2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo the RAM size.
- A store followed by a load to the same address returns the stored data, because the commit happens before the load's DONE.

## Timing
- Reset values:
  - `mem_inst` = NOP, `write_back_inst` = NOP.
  - `mem_addr` = 0, `mem_result` = 0.
  - `freeze_cpu` = 0, `misalign_err` = 0, `wait_cnt` = 0, state IDLE.
  - RAM contents are not reset.
- A non-memory op spends 1 cycle in M.
- A memory op spends `ACCESS_LATENCY`+1 cycles in M, with `freeze_cpu` high for exactly `ACCESS_LATENCY` consecutive cycles.
- `freeze_cpu` rises in the same cycle the memory op is captured into M.
- Reset asserted during WAIT aborts the access: no RAM write, and the outputs take their reset values immediately.
- Back-to-back memory ops each stall independently; there is no overlap of accesses.

## Configuration
- Macro `LSU_MISALIGN_CHECK_EN`.
- Defined: any of the following is misaligned:
  - LH, LHU or SH with `addr[0]`=1.
  - LW or SW with `addr[1:0]`≠0.
- On a misaligned access:
  - no RAM write occurs;
  - a load returns 0;
  - `misalign_err` sets at the DONE edge and stays set until `rst`.
- Undefined:
  - halfword accesses force `addr[0]`=0;
  - word accesses force `addr[1:0]`=0;
  - `misalign_err` is tied to 0.

## Structure
- `lsu_pkg` holds:
  - opcode constants `OPC_LOAD`, `OPC_STORE`;
  - `NOP_INST`;
  - the funct3 enum for widths;
  - the state enum `lsu_state_t` (IDLE/WAIT/DONE).
- Sub-module `lsu_data_ram` holds the RAM: a `DEPTH_WORDS`×32 array with asynchronous read and a synchronous write with a 4-bit byte-enable.
- Lane steering and sign extension stay in `load_store_unit`.

## Test plan
- Reset, then `exe_inst` = ADDI x1,x0,5 with `exe_result`=5: one cycle later `write_back_inst` = ADDI and `mem_result`=5; `freeze_cpu` never rises.
- SW with `exe_result`=0x10 and `exe_store_data`=0xDEADBEEF (`ACCESS_LATENCY`=2): `freeze_cpu` is high for exactly 2 cycles, then the RAM word 4 reads 0xDEADBEEF.
- After that SW, issue LB at 0x13 and LBU at 0x13: `mem_result` is 0xFFFFFFDE and 0x000000DE respectively; `write_back_inst` is NOP during each stall.
- SH of 0x1234 to 0x12, then LW at 0x10: `mem_result`=0x1234BEEF.
- Assert `rst` on the second stall cycle of SW 0x55555555 to 0x20: word 8 is unchanged and all outputs are at reset values immediately.
- With `LSU_MISALIGN_CHECK_EN` defined, LW at 0x11: `mem_result`=0, `misalign_err`=1 and stays set. Undefined: the same LW returns word 4.
